// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with operand forwarding and load-use stall
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int CTRL_W   = 8,
  parameter int LOAD_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_rd1,
  input  logic [31:0]       id_rd2,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_imm,
  input  logic [29:0]       id_pc4,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic              flush,
  input  logic              hold,
  input  logic              mem_wr,
  input  logic [4:0]        mem_dst,
  input  logic [31:0]       mem_res,
  input  logic              wb_wr,
  input  logic [4:0]        wb_dst,
  input  logic [31:0]       wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_imm,
  output logic [29:0]       ex_pc4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd
);

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic        w_rs_hit;
  logic        w_rt_hit;

  // Load-use: the loaded value is not available to forward until the load leaves MEM.
  always_comb begin
    w_rs_hit = id_uses_rs && (id_rs == ex_rt);
    w_rt_hit = id_uses_rt && (id_rt == ex_rt);
    stall    = ex_valid && ex_ctrl[LOAD_BIT] && (ex_rt != 5'd0) && id_valid
               && (w_rs_hit || w_rt_hit);
  end

  // Operand capture: r0 reads as zero; WB write-through covers the same-cycle RF write.
  always_comb begin
    if (id_rs == 5'd0)                       w_rs_val = 32'd0;
    else if (wb_wr && (wb_dst == id_rs))     w_rs_val = wb_data;
    else                                     w_rs_val = id_rd1;

    if (id_rt == 5'd0)                       w_rt_val = 32'd0;
    else if (wb_wr && (wb_dst == id_rt))     w_rt_val = wb_data;
    else                                     w_rt_val = id_rd2;
  end

  always_ff @(posedge clk) begin
    if (rst || (!hold && (flush || stall))) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      ex_imm   <= 32'd0;
      ex_pc4   <= 30'd0;
      ex_rs    <= 5'd0;
      ex_rt    <= 5'd0;
      ex_rd    <= 5'd0;
    end else if (!hold) begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_ctrl;
      r_a      <= w_rs_val;
      r_b      <= w_rt_val;
      ex_imm   <= id_imm;
      ex_pc4   <= id_pc4;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
    end
  end

  // EX forwarding, MEM has priority over WB since it holds the younger result.
  always_comb begin
    if (mem_wr && (mem_dst != 5'd0) && (mem_dst == ex_rs))     ex_a = mem_res;
    else if (wb_wr && (wb_dst != 5'd0) && (wb_dst == ex_rs))   ex_a = wb_data;
    else                                                       ex_a = r_a;

    if (mem_wr && (mem_dst != 5'd0) && (mem_dst == ex_rt))     ex_b = mem_res;
    else if (wb_wr && (wb_dst != 5'd0) && (wb_dst == ex_rt))   ex_b = wb_data;
    else                                                       ex_b = r_b;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/execute boundary stage. Sits directly downstream of the register file and consumes its RD1/RD2 read data, the decoded fields and the control bundle.
- Registers the operands into the EX stage. Forwards results from the MEM and WB stages onto the EX operands.
- Detects load-use hazards and requests a one-cycle stall of IF/ID.
- Accepts a branch/jump flush.

Parameters:
- CTRL_W, 8, width of the decoded control bundle carried into EX.
- LOAD_BIT, 0, index in the control bundle that marks a memory-read (load) instruction.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rd1  in  32  register-file RD1 for the instruction in ID.
- id_rd2  in  32  register-file RD2 for the instruction in ID.
- id_rs, id_rt, id_rd  in  5 each  register fields of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
- id_imm  in  32  sign/zero-extended immediate.
- id_pc4  in  30  word address of PC+4.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_valid  in  1  ID holds a real instruction.
- flush  in  1  branch/jump redirect; kills the instruction entering EX.
- hold  in  1  downstream stall; freezes this stage.
- mem_wr, mem_dst  in  1 / 5  MEM-stage register-write enable and destination.
- mem_res  in  32  MEM-stage ALU result.
- wb_wr, wb_dst  in  1 / 5  WB-stage register-write enable and destination.
- wb_data  in  32  WB-stage write data.
- stall  out  1  load-use stall request to PC and IF/ID (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_a, ex_b  out  32  forwarded operands.
- ex_imm  out  32  registered immediate.
- ex_pc4  out  30  registered PC+4 word address.
- ex_rs, ex_rt, ex_rd  out  5 each  registered register fields.

Behaviour:
- Reset (rst=1 at an edge): all registered state, including ex_valid and ex_ctrl, is cleared to 0. Consequences:
  - ex_a/ex_b read 0 unless a forward matches; no forward can match r0.
  - stall=0 while ex_valid=0.
- Load-use detect (combinational): stall=1 when all of the following hold:
  - ex_valid=1 and ex_ctrl[LOAD_BIT]=1 and ex_rt!=0;
  - id_valid=1;
  - (id_uses_rs and id_rs==ex_rt) or (id_uses_rt and id_rt==ex_rt).
- Edge update priority (highest first):
  - rst: clear all.
  - hold: keep all registers unchanged. stall is still computed, but no bubble is inserted.
  - flush: insert a bubble (ex_valid=0, ex_ctrl=0; other fields don't-care, implemented as 0).
  - stall: insert a bubble. Upstream keeps ID unchanged, so the dependent instruction re-enters next cycle.
  - otherwise: capture all id_* fields; ex_valid<=id_valid.
- Write-through at capture: if wb_wr and wb_dst!=0 and wb_dst==id_rs, the captured rs operand is wb_data, not id_rd1. The same rule applies to rt and id_rd2.
- EX forwarding (combinational). For ex_a:
  - if mem_wr and mem_dst!=0 and mem_dst==ex_rs, use mem_res;
  - else if wb_wr and wb_dst!=0 and wb_dst==ex_rs, use wb_data;
  - else use the registered operand.
  - ex_b uses the same rule with ex_rt.
  - MEM always beats WB.
- Register 0 is never forwarded or written through. A read of r0 yields 0 regardless of id_rd1/id_rd2.
- Latency: one cycle ID→EX. Forwarding adds no cycles; load-use costs exactly one bubble.
- Simultaneous flush and stall: flush wins, stall is still asserted. The bubble is identical either way, and upstream is redirected by flush.
- Reset mid-stall: the next edge clears; stall drops in the same cycle that ex_valid reads 0.

Test Plan:
- Reset → ex_valid=0 and ex_ctrl=0; ex_a=0 with all forwarding inputs inactive; stall=0 even if id_* matches stale fields.
- ID: rs=3, rd1=0x11; MEM: mem_wr=1, mem_dst=3, mem_res=0xAAAA; WB: wb_dst=3, wb_data=0xBBBB → ex_a=0xAAAA. Dropping mem_wr gives ex_a=0xBBBB.
- Load in EX writing rt=5, next instruction reads rs=5 → stall=1 for one cycle, bubble (ex_valid=0), then the dependent instruction enters with ex_rs=5.
- Load with rt=0 followed by a reader of r0 → stall=0; ex_a=0 even with mem_dst=0, mem_res=0xFFFF.
- flush=1 and stall=1 together → ex_valid=0 after the edge. hold=1 → all ex_* registers unchanged across 3 edges.
- Capture with wb_wr=1, wb_dst=7, wb_data=0x1234, id_rt=7, id_rd2=0 → ex_b=0x1234 after the edge, with no other forward active.
